cmd_frame_router: RTL and testbench
===================================

CMD_FRAME_ROUTER -- requirements
Module: cmd_frame_router

Interface
REQ-001 SHALL have parameter NUM_CMDS, default 4, meaning the number of table-driven opcodes (1..16).
REQ-002 SHALL have parameter MAX_PAYLOAD_BYTES, default 32, meaning the widest payload in bytes (1..255).
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 1000000, meaning the maximum idle clocks allowed between payload bytes (0 disables the timeout).
REQ-004 SHALL have parameter OPCODES, default {A0,A1,B0,B1}h, meaning the packed NUM_CMDS x 8-bit opcode table, where entry i is bits [8i+:8].
REQ-005 SHALL have parameter LENGTHS, default {1,32,20,0}, meaning the packed NUM_CMDS x 8-bit payload-length table, where each entry is at most MAX_PAYLOAD_BYTES.
REQ-006 clk  in  1  clock.
REQ-007 rstn  in  1  reset, asynchronous, active-low.
REQ-008 in_valid / in_ready / in_data  in/out/in  1/1/8  command byte stream.
REQ-009 frame_valid  out  1  decoded frame available.
REQ-010 frame_ready  in  1  downstream accepts the frame.
REQ-011 frame_idx  out  $clog2(NUM_CMDS) (min 1)  table index of the decoded opcode.
REQ-012 frame_len  out  8  payload byte count.
REQ-013 frame_data  out  8*MAX_PAYLOAD_BYTES  payload, where payload byte k is at [8k+:8] and unused bytes are 0.
REQ-014 resp_valid / resp_ready / resp_data  out/in/out  1/1/8  status byte stream.
REQ-015 cmd_reset  out  1  one-cycle system reset request.

Function
REQ-016 SHALL implement the states IDLE, RST_CHK, PAYLOAD, EMIT and RESP.
REQ-017 in_ready SHALL be 1 in IDLE, RST_CHK and PAYLOAD, and 0 in EMIT and RESP.
REQ-018 A transfer SHALL occur only on a cycle where in_valid and in_ready are both 1.
REQ-019 IDLE, byte 55h: SHALL go to RST_CHK; 55h is reserved and SHALL never be looked up in OPCODES.
REQ-020 RST_CHK, byte 55h: SHALL pulse cmd_reset for exactly 1 cycle on the next clock and SHALL go to IDLE without a response.
REQ-021 RST_CHK, any other byte: SHALL queue response E2h and go to RESP.
REQ-022 IDLE, byte matching OPCODES[i]: SHALL latch frame_idx=i and frame_len=LENGTHS[i], clear frame_data and the byte counter, then go to PAYLOAD if LENGTHS[i]>0, otherwise to EMIT.
REQ-023 If multiple table entries match, the lowest index SHALL win.
REQ-024 IDLE, byte matching no table entry and not 55h: SHALL queue response E0h and go to RESP.
REQ-025 PAYLOAD: each transferred byte SHALL be written to frame_data[8*cnt+:8] and cnt SHALL be incremented.
REQ-026 PAYLOAD: when the byte with cnt==frame_len-1 is transferred, SHALL go to EMIT on the next clock.
REQ-027 Timeout: the idle counter SHALL clear on every transferred byte and on PAYLOAD entry, and SHALL increment on every PAYLOAD cycle without a transfer.
REQ-028 Timeout: when the idle counter reaches TIMEOUT_CYCLES (if nonzero), SHALL discard the partial frame, queue response E1h and go to RESP; frame_valid SHALL never assert for that frame.
REQ-029 EMIT: frame_valid SHALL be 1, and frame_idx, frame_len and frame_data SHALL be stable until frame_ready is 1.
REQ-030 EMIT: on frame_valid and frame_ready, SHALL queue response ACh and go to RESP.
REQ-031 EMIT: SHALL wait indefinitely; backpressure SHALL NOT trigger the timeout.
REQ-032 RESP: resp_valid SHALL be 1 with resp_data stable until resp_ready is 1, then SHALL go to IDLE on the next clock.
REQ-033 Latency: frame_valid SHALL rise 1 clock after the last payload byte transfer, or 1 clock after the opcode transfer for zero-length commands.
REQ-034 Latency: resp_valid SHALL rise 1 clock after the frame handshake or error detection.
REQ-035 Every decoded frame SHALL produce exactly one response byte, and responses SHALL be emitted in frame order.
REQ-036 frame_valid, resp_valid and cmd_reset SHALL be registered outputs.
REQ-037 Counters: cnt SHALL be 8 bits; the idle counter SHALL be $clog2(TIMEOUT_CYCLES+1) bits and SHALL saturate, never wrap.

Reset
REQ-038 While rstn is 0, the block SHALL be in state IDLE.
REQ-039 While rstn is 0, in_ready SHALL be 0, and SHALL be 1 from the first clock after rstn is released.
REQ-040 While rstn is 0, frame_valid, resp_valid and cmd_reset SHALL be 0; frame_idx, frame_len, frame_data and resp_data SHALL be 0; all counters SHALL be 0.
REQ-041 Reset asserted mid-frame SHALL drop the partial frame without emitting any response.

Verification
REQ-042 Stream A0h,07h with default parameters -> frame_valid with frame_idx=0, frame_len=1, frame_data[7:0]=07h; after the frame handshake, resp_data=ACh.
REQ-043 Stream B1h -> frame_valid 1 clock later with frame_idx=3, frame_len=0, frame_data=0, then response ACh.
REQ-044 Stream A1h followed by 32 bytes 00h..1Fh with frame_ready held 0 for 50 clocks -> in_ready=0 and frame_data stable throughout; on release, frame_data[255:248]=1Fh and response ACh.
REQ-045 Stream 55h,55h -> cmd_reset high for exactly 1 cycle and no response; stream 55h,12h -> response E2h and cmd_reset stays 0.
REQ-046 Stream 3Ch -> response E0h; stream B0h plus 5 bytes, then idle with TIMEOUT_CYCLES=16 -> after 16 idle clocks, response E1h and no frame_valid.
REQ-047 Stream A1h plus 10 bytes, then pulse rstn low -> all outputs 0 and no response; a following A0h,07h decodes normally.

Source files
------------

// File: rtl/cmd_frame_router_if.sv
// Command router bus: input byte stream, decoded frame and status byte.
// master is the host side, slave is the router.
interface cmd_frame_router_if #(
  parameter int NUM_CMDS          = 4,
  parameter int MAX_PAYLOAD_BYTES = 32
);
  localparam int IDX_W = (NUM_CMDS > 1) ? $clog2(NUM_CMDS) : 1;

  logic                           in_valid;
  logic                           in_ready;
  logic [7:0]                     in_data;
  logic                           frame_valid;
  logic                           frame_ready;
  logic [IDX_W-1:0]               frame_idx;
  logic [7:0]                     frame_len;
  logic [8*MAX_PAYLOAD_BYTES-1:0] frame_data;
  logic                           resp_valid;
  logic                           resp_ready;
  logic [7:0]                     resp_data;

  modport master (
    output in_valid, in_data, frame_ready, resp_ready,
    input  in_ready, frame_valid, frame_idx, frame_len,
    input  frame_data, resp_valid, resp_data
  );

  modport slave (
    input  in_valid, in_data, frame_ready, resp_ready,
    output in_ready, frame_valid, frame_idx, frame_len,
    output frame_data, resp_valid, resp_data
  );
endinterface

// File: rtl/cmd_frame_router.sv
// Table-driven command decoder: opcode + payload -> frame, one status
// byte per command, 55h 55h requests a system reset.
module cmd_frame_router #(
  parameter int NUM_CMDS          = 4,
  parameter int MAX_PAYLOAD_BYTES = 32,
  parameter int TIMEOUT_CYCLES    = 1000000,
  parameter logic [8*NUM_CMDS-1:0] OPCODES = 32'hB1B0_A1A0,
  parameter logic [8*NUM_CMDS-1:0] LENGTHS = 32'h0014_2001
) (
  input  logic                    clk,
  input  logic                    rstn,
  cmd_frame_router_if.slave       bus,
  output logic                    cmd_reset
);

  localparam int IDX_W = (NUM_CMDS > 1) ? $clog2(NUM_CMDS) : 1;
  localparam int DW    = 8 * MAX_PAYLOAD_BYTES;
  localparam int IW    = (TIMEOUT_CYCLES > 0) ?
                         $clog2(TIMEOUT_CYCLES + 1) : 1;

  localparam logic [IW-1:0] IDLE_MAX = {IW{1'b1}};
  localparam logic [IW-1:0] IDLE_TO  = IW'(TIMEOUT_CYCLES);
  localparam logic [7:0]    RST_BYTE = 8'h55;
  localparam logic [7:0]    R_ACK    = 8'hAC;
  localparam logic [7:0]    R_BADOP  = 8'hE0;
  localparam logic [7:0]    R_TOUT   = 8'hE1;
  localparam logic [7:0]    R_BADRST = 8'hE2;

  typedef enum logic [2:0] {
    IDLE,
    RST_CHK,
    PAYLOAD,
    EMIT,
    RESP
  } state_e;

  state_e           state_q, state_d;
  logic             in_ready_q, in_ready_d;
  logic             frame_valid_q, frame_valid_d;
  logic             resp_valid_q, resp_valid_d;
  logic             cmd_reset_q, cmd_reset_d;
  logic [IDX_W-1:0] frame_idx_q, frame_idx_d;
  logic [7:0]       frame_len_q, frame_len_d;
  logic [DW-1:0]    frame_data_q, frame_data_d;
  logic [7:0]       resp_data_q, resp_data_d;
  logic [7:0]       cnt_q, cnt_d;
  logic [IW-1:0]    idle_q, idle_d;

  logic             xfer;
  logic             hit;
  logic [IDX_W-1:0] hit_idx;
  logic [7:0]       hit_len;
  logic [IW-1:0]    idle_inc;

  assign xfer     = bus.in_valid & in_ready_q;
  assign idle_inc = (idle_q == IDLE_MAX) ? idle_q : idle_q + IW'(1);

  // Scan high to low so the lowest matching index is the one kept.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    hit_len = '0;
    for (int i = NUM_CMDS - 1; i >= 0; i--) begin
      if (bus.in_data == OPCODES[8*i +: 8]) begin
        hit     = 1'b1;
        hit_idx = IDX_W'(i);
        hit_len = LENGTHS[8*i +: 8];
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    frame_idx_d  = frame_idx_q;
    frame_len_d  = frame_len_q;
    frame_data_d = frame_data_q;
    resp_data_d  = resp_data_q;
    cnt_d        = cnt_q;
    idle_d       = idle_q;
    cmd_reset_d  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (xfer) begin
          if (bus.in_data == RST_BYTE) begin
            state_d = RST_CHK;
          end else if (hit) begin
            frame_idx_d  = hit_idx;
            frame_len_d  = hit_len;
            frame_data_d = '0;
            cnt_d        = '0;
            idle_d       = '0;
            state_d      = (hit_len != 8'd0) ? PAYLOAD : EMIT;
          end else begin
            resp_data_d = R_BADOP;
            state_d     = RESP;
          end
        end
      end

      RST_CHK: begin
        if (xfer) begin
          if (bus.in_data == RST_BYTE) begin
            cmd_reset_d = 1'b1;
            state_d     = IDLE;
          end else begin
            resp_data_d = R_BADRST;
            state_d     = RESP;
          end
        end
      end

      PAYLOAD: begin
        if (xfer) begin
          for (int k = 0; k < MAX_PAYLOAD_BYTES; k++) begin
            if (cnt_q == 8'(k)) begin
              frame_data_d[8*k +: 8] = bus.in_data;
            end
          end
          cnt_d  = cnt_q + 8'd1;
          idle_d = '0;
          if (cnt_q == frame_len_q - 8'd1) begin
            state_d = EMIT;
          end
        end else begin
          idle_d = idle_inc;
          if (TIMEOUT_CYCLES != 0 && idle_inc == IDLE_TO) begin
            frame_idx_d  = '0;
            frame_len_d  = '0;
            frame_data_d = '0;
            cnt_d        = '0;
            resp_data_d  = R_TOUT;
            state_d      = RESP;
          end
        end
      end

      EMIT: begin
        if (frame_valid_q && bus.frame_ready) begin
          resp_data_d = R_ACK;
          state_d     = RESP;
        end
      end

      RESP: begin
        if (bus.resp_ready) begin
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase

    in_ready_d    = (state_d == IDLE) || (state_d == RST_CHK) ||
                    (state_d == PAYLOAD);
    frame_valid_d = (state_d == EMIT);
    resp_valid_d  = (state_d == RESP);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q       <= IDLE;
      in_ready_q    <= 1'b0;
      frame_valid_q <= 1'b0;
      resp_valid_q  <= 1'b0;
      cmd_reset_q   <= 1'b0;
      frame_idx_q   <= '0;
      frame_len_q   <= '0;
      frame_data_q  <= '0;
      resp_data_q   <= '0;
      cnt_q         <= '0;
      idle_q        <= '0;
    end else begin
      state_q       <= state_d;
      in_ready_q    <= in_ready_d;
      frame_valid_q <= frame_valid_d;
      resp_valid_q  <= resp_valid_d;
      cmd_reset_q   <= cmd_reset_d;
      frame_idx_q   <= frame_idx_d;
      frame_len_q   <= frame_len_d;
      frame_data_q  <= frame_data_d;
      resp_data_q   <= resp_data_d;
      cnt_q         <= cnt_d;
      idle_q        <= idle_d;
    end
  end

  assign bus.in_ready    = in_ready_q;
  assign bus.frame_valid = frame_valid_q;
  assign bus.frame_idx   = frame_idx_q;
  assign bus.frame_len   = frame_len_q;
  assign bus.frame_data  = frame_data_q;
  assign bus.resp_valid  = resp_valid_q;
  assign bus.resp_data   = resp_data_q;
  assign cmd_reset       = cmd_reset_q;

endmodule

// File: tb/tb_cmd_frame_router.sv
// Bench for cmd_frame_router: directed scenarios plus a random command
// stream checked against a stream-level parser model.
module tb_cmd_frame_router;

  typedef struct {
    logic [1:0]   idx;
    logic [7:0]   len;
    logic [255:0] data;
  } frm_t;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic cmd_reset;

  always #5 clk = ~clk;

  cmd_frame_router_if #(.NUM_CMDS(4), .MAX_PAYLOAD_BYTES(32)) bus ();

  cmd_frame_router #(
    .NUM_CMDS(4),
    .MAX_PAYLOAD_BYTES(32),
    .TIMEOUT_CYCLES(16),
    .OPCODES(32'hB1B0_A1A0),
    .LENGTHS(32'h0014_2001)
  ) dut (
    .clk(clk),
    .rstn(rstn),
    .bus(bus),
    .cmd_reset(cmd_reset)
  );

  int n_checks = 0;
  int n_fail = 0;

  logic [7:0] ops  [4] = '{8'hA0, 8'hA1, 8'hB0, 8'hB1};
  int         lens [4] = '{1, 32, 20, 0};

  frm_t       got_f[$], exp_f[$];
  logic [7:0] got_r[$], exp_r[$];
  int         crst_cnt, exp_crst, fv_cycles;
  bit         rand_rdy = 0;

  always @(negedge clk) begin
    if (rstn) begin
      if (bus.frame_valid) fv_cycles++;
      if (bus.frame_valid && bus.frame_ready)
        got_f.push_back('{bus.frame_idx, bus.frame_len, bus.frame_data});
      if (bus.resp_valid && bus.resp_ready)
        got_r.push_back(bus.resp_data);
      if (cmd_reset) crst_cnt++;
    end
  end

  always @(posedge clk) begin
    if (rand_rdy) begin
      #1;
      bus.frame_ready = 1'($urandom_range(0, 1));
      bus.resp_ready  = 1'($urandom_range(0, 1));
    end
  end

  task automatic clear_logs();
    got_f.delete(); exp_f.delete();
    got_r.delete(); exp_r.delete();
    crst_cnt = 0; exp_crst = 0; fv_cycles = 0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int n = 0;
    repeat (gap) @(negedge clk);
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_data  = b;
    while (!bus.in_ready && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (n >= 500) begin
      n_checks++; n_fail++;
      $display("FAIL send_wait byte=%h in_ready stuck 0, required 1", b);
      bus.in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    int quiet = 0;
    int n = 0;
    while (quiet < 3 && n < 3000) begin
      @(negedge clk);
      n++;
      if (bus.in_ready && !bus.frame_valid && !bus.resp_valid) quiet++;
      else quiet = 0;
    end
    n_checks++;
    if (quiet < 3) begin
      n_fail++;
      $display("FAIL drain got busy, required idle within 3000 cycles");
    end
  endtask

  // Stream-level reference: parse bytes into frames, responses, resets.
  task automatic model_stream(input logic [7:0] s[$]);
    int i = 0;
    while (i < s.size()) begin
      logic [7:0] b;
      int found;
      b = s[i];
      i++;
      if (b == 8'h55) begin
        if (i < s.size()) begin
          if (s[i] == 8'h55) exp_crst++;
          else exp_r.push_back(8'hE2);
          i++;
        end
      end else begin
        found = -1;
        for (int j = 0; j < 4; j++)
          if (found < 0 && ops[j] == b) found = j;
        if (found >= 0) begin
          frm_t f;
          f.idx  = 2'(found);
          f.len  = 8'(lens[found]);
          f.data = '0;
          for (int k = 0; k < lens[found]; k++)
            f.data[8*k +: 8] = s[i + k];
          i += lens[found];
          exp_f.push_back(f);
          exp_r.push_back(8'hAC);
        end else begin
          exp_r.push_back(8'hE0);
        end
      end
    end
  endtask

  task automatic test_reset();
    bus.in_valid = 0; bus.in_data = 0;
    bus.frame_ready = 0; bus.resp_ready = 0;
    rstn = 0;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({bus.in_ready, bus.frame_valid, bus.resp_valid, cmd_reset} !== 4'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl got %b, required 0000",
        {bus.in_ready, bus.frame_valid, bus.resp_valid, cmd_reset});
    end
    n_checks++;
    if (bus.frame_idx !== 0 || bus.frame_len !== 0 ||
        bus.frame_data !== 0 || bus.resp_data !== 0) begin
      n_fail++;
      $display("FAIL reset_data idx=%h len=%h resp=%h, required all 0",
        bus.frame_idx, bus.frame_len, bus.resp_data);
    end
    rstn = 1;
    #1;
    n_checks++;
    if (bus.in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL release_ready got %b before clock, required 0", bus.in_ready);
    end
    @(negedge clk);
    n_checks++;
    if (bus.in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL first_clock_ready got %b, required 1", bus.in_ready);
    end
  endtask

  task automatic test_basic();
    clear_logs();
    bus.frame_ready = 1; bus.resp_ready = 1;
    send_byte(8'hA0, 0);
    send_byte(8'h07, 0);
    @(negedge clk);
    n_checks++;
    if (bus.frame_valid !== 1'b1 || bus.frame_idx !== 2'd0 ||
        bus.frame_len !== 8'd1 || bus.frame_data !== 256'h07) begin
      n_fail++;
      $display("FAIL basic_frame v=%b idx=%0d len=%0d d=%h, required 1 0 1 07",
        bus.frame_valid, bus.frame_idx, bus.frame_len, bus.frame_data[7:0]);
    end
    @(negedge clk);
    n_checks++;
    if (bus.resp_valid !== 1'b1 || bus.resp_data !== 8'hAC) begin
      n_fail++;
      $display("FAIL basic_resp v=%b d=%h, required 1 ac",
        bus.resp_valid, bus.resp_data);
    end
    drain();
  endtask

  task automatic test_zero_len();
    clear_logs();
    bus.frame_ready = 0; bus.resp_ready = 1;
    send_byte(8'hB1, 0);
    @(negedge clk);
    n_checks++;
    if (bus.frame_valid !== 1'b1 || bus.frame_idx !== 2'd3 ||
        bus.frame_len !== 8'd0 || bus.frame_data !== 256'h0) begin
      n_fail++;
      $display("FAIL zero_len_frame v=%b idx=%0d len=%0d, required 1 3 0 data 0",
        bus.frame_valid, bus.frame_idx, bus.frame_len);
    end
    @(posedge clk);
    #1 bus.frame_ready = 1;
    drain();
    n_checks++;
    if (got_r.size() != 1 || got_r[0] !== 8'hAC) begin
      n_fail++;
      $display("FAIL zero_len_resp count=%0d, required one ac", got_r.size());
    end
  endtask

  task automatic test_backpressure();
    logic [255:0] snap, want;
    int bad = 0;
    clear_logs();
    bus.frame_ready = 0; bus.resp_ready = 1;
    want = '0;
    send_byte(8'hA1, 0);
    for (int k = 0; k < 32; k++) begin
      send_byte(8'(k), 0);
      want[8*k +: 8] = 8'(k);
    end
    @(negedge clk);
    snap = bus.frame_data;
    n_checks++;
    if (bus.frame_valid !== 1'b1 || snap !== want) begin
      n_fail++;
      $display("FAIL bp_frame v=%b d=%h, required 1 %h", bus.frame_valid, snap, want);
    end
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      n_checks++;
      if (bus.in_ready !== 1'b0 || bus.frame_valid !== 1'b1 ||
          bus.frame_data !== snap) begin
        n_fail++; bad++;
        if (bad < 4)
          $display("FAIL bp_hold cycle %0d rdy=%b v=%b, required 0 1 stable",
            c, bus.in_ready, bus.frame_valid);
      end
    end
    n_checks++;
    if (bus.frame_data[255:248] !== 8'h1F) begin
      n_fail++;
      $display("FAIL bp_last got %h, required 1f", bus.frame_data[255:248]);
    end
    @(posedge clk);
    #1 bus.frame_ready = 1;
    drain();
    n_checks++;
    if (got_r.size() != 1 || got_r[0] !== 8'hAC || got_f.size() != 1) begin
      n_fail++;
      $display("FAIL bp_resp resps=%0d frames=%0d, required 1 ac and 1 frame",
        got_r.size(), got_f.size());
    end
  endtask

  task automatic test_reset_cmd();
    clear_logs();
    bus.frame_ready = 1; bus.resp_ready = 1;
    send_byte(8'h55, 0);
    send_byte(8'h55, 0);
    drain();
    n_checks++;
    if (crst_cnt != 1 || got_r.size() != 0) begin
      n_fail++;
      $display("FAIL rst_pulse cycles=%0d resps=%0d, required 1 0",
        crst_cnt, got_r.size());
    end
    clear_logs();
    send_byte(8'h55, 0);
    send_byte(8'h12, 0);
    drain();
    n_checks++;
    if (crst_cnt != 0 || got_r.size() != 1 || got_r[0] !== 8'hE2) begin
      n_fail++;
      $display("FAIL rst_bad cycles=%0d resps=%0d, required 0 and one e2",
        crst_cnt, got_r.size());
    end
  endtask

  task automatic test_unknown_timeout();
    clear_logs();
    bus.frame_ready = 1; bus.resp_ready = 1;
    send_byte(8'h3C, 0);
    drain();
    n_checks++;
    if (got_r.size() != 1 || got_r[0] !== 8'hE0) begin
      n_fail++;
      $display("FAIL unknown_op resps=%0d, required one e0", got_r.size());
    end
    clear_logs();
    bus.resp_ready = 0;
    send_byte(8'hB0, 0);
    for (int k = 0; k < 5; k++) send_byte(8'($urandom), 0);
    repeat (15) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (bus.resp_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL timeout_early resp_valid=%b after 15 idle, required 0",
        bus.resp_valid);
    end
    @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (bus.resp_valid !== 1'b1 || bus.resp_data !== 8'hE1) begin
      n_fail++;
      $display("FAIL timeout_resp v=%b d=%h after 16 idle, required 1 e1",
        bus.resp_valid, bus.resp_data);
    end
    @(posedge clk);
    #1 bus.resp_ready = 1;
    drain();
    n_checks++;
    if (fv_cycles != 0 || got_f.size() != 0 || got_r.size() != 1) begin
      n_fail++;
      $display("FAIL timeout_noframe fv=%0d frames=%0d resps=%0d, required 0 0 1",
        fv_cycles, got_f.size(), got_r.size());
    end
  endtask

  task automatic test_mid_reset();
    clear_logs();
    bus.frame_ready = 1; bus.resp_ready = 1;
    send_byte(8'hA1, 0);
    for (int k = 0; k < 10; k++) send_byte(8'(k + 8'h40), 0);
    @(negedge clk);
    rstn = 0;
    @(negedge clk);
    n_checks++;
    if ({bus.in_ready, bus.frame_valid, bus.resp_valid, cmd_reset} !== 4'b0 ||
        bus.frame_data !== 0 || bus.frame_len !== 0 ||
        bus.frame_idx !== 0 || bus.resp_data !== 0) begin
      n_fail++;
      $display("FAIL midrst_outs ctrl=%b len=%h, required all 0",
        {bus.in_ready, bus.frame_valid, bus.resp_valid, cmd_reset},
        bus.frame_len);
    end
    repeat (2) @(negedge clk);
    rstn = 1;
    drain();
    n_checks++;
    if (got_r.size() != 0 || got_f.size() != 0) begin
      n_fail++;
      $display("FAIL midrst_silent resps=%0d frames=%0d, required 0 0",
        got_r.size(), got_f.size());
    end
    send_byte(8'hA0, 0);
    send_byte(8'h07, 0);
    drain();
    n_checks++;
    if (got_f.size() != 1 || got_r.size() != 1 || got_r[0] !== 8'hAC ||
        got_f[0].idx !== 2'd0 || got_f[0].len !== 8'd1 ||
        got_f[0].data !== 256'h07) begin
      n_fail++;
      $display("FAIL midrst_recover frames=%0d resps=%0d, required 1 1",
        got_f.size(), got_r.size());
    end
  endtask

  task automatic test_random();
    logic [7:0] s[$];
    clear_logs();
    for (int c = 0; c < 40; c++) begin
      int t = $urandom_range(0, 5);
      if (t < 4) begin
        s.push_back(ops[t]);
        for (int k = 0; k < lens[t]; k++) s.push_back(8'($urandom));
      end else if (t == 4) begin
        s.push_back(8'h55);
        s.push_back(($urandom_range(0, 1) == 1) ? 8'h55 : 8'h2A);
      end else begin
        logic [7:0] b;
        b = 8'($urandom);
        while (b == 8'h55 || b == 8'hA0 || b == 8'hA1 ||
               b == 8'hB0 || b == 8'hB1)
          b = 8'($urandom);
        s.push_back(b);
      end
    end
    model_stream(s);
    rand_rdy = 1;
    foreach (s[i]) send_byte(s[i], $urandom_range(0, 3));
    repeat (40) @(negedge clk);
    rand_rdy = 0;
    @(posedge clk);
    #2;
    bus.frame_ready = 1; bus.resp_ready = 1;
    drain();
    n_checks++;
    if (got_f.size() != exp_f.size() || got_r.size() != exp_r.size() ||
        crst_cnt != exp_crst) begin
      n_fail++;
      $display("FAIL rand_counts f=%0d r=%0d rst=%0d, required %0d %0d %0d",
        got_f.size(), got_r.size(), crst_cnt,
        exp_f.size(), exp_r.size(), exp_crst);
    end else begin
      foreach (exp_f[i]) begin
        n_checks++;
        if (got_f[i].idx !== exp_f[i].idx || got_f[i].len !== exp_f[i].len ||
            got_f[i].data !== exp_f[i].data) begin
          n_fail++;
          $display("FAIL rand_frame %0d idx=%0d len=%0d, required %0d %0d",
            i, got_f[i].idx, got_f[i].len, exp_f[i].idx, exp_f[i].len);
        end
      end
      foreach (exp_r[i]) begin
        n_checks++;
        if (got_r[i] !== exp_r[i]) begin
          n_fail++;
          $display("FAIL rand_resp %0d got %h, required %h",
            i, got_r[i], exp_r[i]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_zero_len();
    test_backpressure();
    test_reset_cmd();
    test_unknown_timeout();
    test_mid_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures",
      n_checks, n_fail);
    $finish;
  end

endmodule
